// File: rtl/obstacle_guard.sv
// obstacle_guard: collision responder for the snake mover.
// Samples the snake position/size and keyboard state each frame. It flags
// overlap with one rectangular obstacle (OB1Flag), reports the push-out
// direction (motionFlag) and counts distinct collisions (hit_count).
module obstacle_guard #(
    parameter int unsigned OB_LEFT        = 300,
    parameter int unsigned OB_RIGHT       = 339,
    parameter int unsigned OB_TOP         = 200,
    parameter int unsigned OB_BOTTOM      = 239,
    parameter int unsigned RECOVER_FRAMES = 4
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  BallS,
    output logic        OB1Flag,
    output logic [1:0]  motionFlag,
    output logic [7:0]  hit_count
);

    // Keyboard usage codes for the four travel keys.
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    // Push direction encodings (opposite to the direction of travel).
    localparam logic [1:0] DIR_PUSH_POS_Y = 2'b00;
    localparam logic [1:0] DIR_PUSH_POS_X = 2'b01;
    localparam logic [1:0] DIR_PUSH_NEG_Y = 2'b10;
    localparam logic [1:0] DIR_PUSH_NEG_X = 2'b11;

    // Obstacle bounds widened to the 11-bit overlap arithmetic.
    localparam logic [10:0] LEFT11   = 11'(OB_LEFT);
    localparam logic [10:0] RIGHT11  = 11'(OB_RIGHT);
    localparam logic [10:0] TOP11    = 11'(OB_TOP);
    localparam logic [10:0] BOTTOM11 = 11'(OB_BOTTOM);

    // Recovery counter sized to hold RECOVER_FRAMES.
    localparam int unsigned RW = $clog2(RECOVER_FRAMES + 1);
    localparam logic [RW-1:0] REC_INIT = RW'(RECOVER_FRAMES);
    localparam logic [RW-1:0] REC_ONE  = RW'(1);

    typedef enum logic [1:0] {
        CLEAR,
        HIT,
        RECOVER
    } state_t;

    state_t        state;
    logic [1:0]    last_dir;
    logic [1:0]    new_dir;
    logic [RW-1:0] rec_cnt;

    logic [10:0] lx, rx, ty, by;
    logic        ovl;

    function automatic logic is_dir_key(input logic [7:0] k);
        return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
    endfunction

    function automatic logic [1:0] key_to_dir(input logic [7:0] k);
        logic [1:0] d;
        d = DIR_PUSH_POS_Y;
        case (k)
            KEY_W:   d = DIR_PUSH_POS_Y;
            KEY_A:   d = DIR_PUSH_POS_X;
            KEY_S:   d = DIR_PUSH_NEG_Y;
            KEY_D:   d = DIR_PUSH_NEG_X;
            default: d = DIR_PUSH_POS_Y;
        endcase
        return d;
    endfunction

    // Direction implied by this frame's keys; upper slot wins, no key keeps the old one.
    always_comb begin
        new_dir = last_dir;
        if (is_dir_key(keycode[15:8])) begin
            new_dir = key_to_dir(keycode[15:8]);
        end else if (is_dir_key(keycode[7:0])) begin
            new_dir = key_to_dir(keycode[7:0]);
        end
    end

    // Sprite bounding box and rectangle overlap; left/top edges clamp at zero instead of wrapping.
    always_comb begin
        lx  = (BallX < BallS) ? '0 : ({1'b0, BallX} - {1'b0, BallS});
        rx  = {1'b0, BallX} + {1'b0, BallS};
        ty  = (BallY < BallS) ? '0 : ({1'b0, BallY} - {1'b0, BallS});
        by  = {1'b0, BallY} + {1'b0, BallS};
        ovl = (rx >= LEFT11) && (lx <= RIGHT11) && (by >= TOP11) && (ty <= BOTTOM11);
    end

    // Last travel direction, tracked every frame regardless of collision state.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            last_dir <= '0;
        end else begin
            last_dir <= new_dir;
        end
    end

    // Collision FSM with registered flag, push direction and collision counter.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= CLEAR;
            OB1Flag    <= 1'b0;
            motionFlag <= '0;
            hit_count  <= '0;
            rec_cnt    <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    motionFlag <= new_dir;
                    if (ovl) begin
                        state   <= HIT;
                        OB1Flag <= 1'b1;
                        if (hit_count != '1) begin
                            hit_count <= hit_count + 8'd1;
                        end
                    end
                end
                HIT: begin
                    if (!ovl) begin
                        state   <= RECOVER;
                        rec_cnt <= REC_INIT;
                    end
                end
                RECOVER: begin
                    if (ovl) begin
                        // Re-contact while recovering is the same collision: no count.
                        state   <= HIT;
                        rec_cnt <= '0;
                    end else if (rec_cnt > REC_ONE) begin
                        rec_cnt <= rec_cnt - REC_ONE;
                    end else begin
                        state      <= CLEAR;
                        rec_cnt    <= '0;
                        OB1Flag    <= 1'b0;
                        motionFlag <= new_dir;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    OB1Flag <= 1'b0;
                    rec_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_guard.sv
// tb_obstacle_guard: randomized and directed bench for obstacle_guard.
// Two instances run in parallel: the default obstacle and one with its left
// edge at x=0, so the clamped left edge is exercised near the screen border.
module tb_obstacle_guard;

    localparam int REC = 4;

    logic        frame_clk;
    logic        Reset;
    logic [15:0] keycode;
    logic [9:0]  BallX, BallY, BallS;

    logic       ob_a, ob_b;
    logic [1:0] mf_a, mf_b;
    logic [7:0] hc_a, hc_b;

    int n_checks = 0;
    int n_fail   = 0;

    obstacle_guard #(
        .OB_LEFT(300), .OB_RIGHT(339), .OB_TOP(200), .OB_BOTTOM(239), .RECOVER_FRAMES(REC)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .OB1Flag(ob_a), .motionFlag(mf_a), .hit_count(hc_a)
    );

    obstacle_guard #(
        .OB_LEFT(0), .OB_RIGHT(339), .OB_TOP(200), .OB_BOTTOM(239), .RECOVER_FRAMES(REC)
    ) dut0 (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .OB1Flag(ob_b), .motionFlag(mf_b), .hit_count(hc_b)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int lefts[2] = '{300, 0};
    int m_dir;
    int m_blk[2], m_miss[2], m_mot[2], m_hits[2];

    function automatic int key_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h04:   return 1;
            8'h16:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int overlaps(input int left, input int x, input int y, input int s);
        int l, r, t, b;
        l = (x - s < 0) ? 0 : x - s;
        r = x + s;
        t = (y - s < 0) ? 0 : y - s;
        b = y + s;
        return (r >= left && l <= 339 && b >= 200 && t <= 239) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_dir = 0;
        for (int i = 0; i < 2; i++) begin
            m_blk[i] = 0; m_miss[i] = 0; m_mot[i] = 0; m_hits[i] = 0;
        end
    endtask

    // Model: blocked until REC+1 consecutive overlap-free frames; push frozen while blocked.
    task automatic model_step();
        int d, o;
        d = key_dir(keycode[15:8]);
        if (d < 0) d = key_dir(keycode[7:0]);
        if (d >= 0) m_dir = d;
        for (int i = 0; i < 2; i++) begin
            o = overlaps(lefts[i], int'(BallX), int'(BallY), int'(BallS));
            if (m_blk[i] == 0) begin
                m_mot[i] = m_dir;
                if (o == 1) begin
                    m_blk[i] = 1;
                    m_miss[i] = 0;
                    if (m_hits[i] < 255) m_hits[i]++;
                end
            end else if (o == 1) begin
                m_miss[i] = 0;
            end else begin
                m_miss[i]++;
                if (m_miss[i] == REC + 1) begin
                    m_blk[i] = 0;
                    m_miss[i] = 0;
                    m_mot[i] = m_dir;
                end
            end
        end
    endtask

    // Per-cycle compare of both instances against the model.
    initial begin
        model_reset();
        forever begin
            @(posedge frame_clk);
            if (Reset) model_reset();
            else model_step();
            #1;
            check("ob_a", int'(ob_a), m_blk[0]);
            check("mf_a", int'(mf_a), m_mot[0]);
            check("hc_a", int'(hc_a), m_hits[0]);
            check("ob_b", int'(ob_b), m_blk[1]);
            check("mf_b", int'(mf_b), m_mot[1]);
            check("hc_b", int'(hc_b), m_hits[1]);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [15:0] k, input int x, input int y, input int s);
        @(negedge frame_clk);
        keycode = k;
        BallX = 10'(x);
        BallY = 10'(y);
        BallS = 10'(s);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #2;
    endtask

    function automatic logic [7:0] pick_key();
        int unsigned r;
        r = $urandom_range(0, 6);
        case (r)
            0: return 8'h1A;
            1: return 8'h04;
            2: return 8'h16;
            3: return 8'h07;
            4: return 8'h28;
            5: return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        Reset = 1'b1;
        keycode = '0;
        BallX = '0; BallY = '0; BallS = '0;
        #3;
        check("reset_ob", int'(ob_a), 0);
        check("reset_mf", int'(mf_a), 0);
        check("reset_hc", int'(hc_a), 0);
        @(negedge frame_clk);
        Reset = 1'b0;

        // Just short of the left edge, then exactly touching it.
        drive(16'h0007, 287, 220, 12); tick();
        check("near_ob", int'(ob_a), 0);
        check("near_mf", int'(mf_a), 3);
        drive(16'h0007, 288, 220, 12); tick();
        check("touch_ob", int'(ob_a), 1);
        check("touch_mf", int'(mf_a), 3);
        check("touch_hc", int'(hc_a), 1);

        // Key change while blocked leaves the push frozen.
        drive(16'h0004, 288, 220, 12); tick();
        check("frozen_mf", int'(mf_a), 3);

        // Release: flag holds for four frames, drops on the fifth.
        drive(16'h0004, 287, 220, 12);
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("recover_ob", int'(ob_a), (e < 5) ? 1 : 0);
        end
        check("recover_mf", int'(mf_a), 1);

        // New collision, then re-contact during recovery does not recount.
        drive(16'h0004, 288, 220, 12); tick();
        check("hit2_hc", int'(hc_a), 2);
        drive(16'h0004, 287, 220, 12); tick(); tick();
        drive(16'h0004, 288, 220, 12); tick();
        check("rehit_ob", int'(ob_a), 1);
        check("rehit_hc", int'(hc_a), 2);
        check("rehit_mf", int'(mf_a), 1);

        // Reset asserted in the middle of recovery.
        drive(16'h0004, 287, 220, 12); tick(); tick(); tick();
        @(negedge frame_clk);
        Reset = 1'b1;
        #1;
        check("midrst_ob", int'(ob_a), 0);
        check("midrst_mf", int'(mf_a), 0);
        check("midrst_hc", int'(hc_a), 0);
        @(negedge frame_clk);
        Reset = 1'b0;

        // Key priority and non-direction keys while clear.
        drive(16'h0016, 100, 220, 12); tick();
        check("clr_ob", int'(ob_a), 0);
        check("key_s", int'(mf_a), 2);
        drive(16'h1A04, 100, 220, 12); tick();
        check("key_upper", int'(mf_a), 0);
        drive(16'h0007, 100, 220, 12); tick();
        check("key_d", int'(mf_a), 3);
        drive(16'h0028, 100, 220, 12); tick();
        check("key_other", int'(mf_a), 3);

        // Near the screen edge: left edge clamps to 0 instead of wrapping.
        drive(16'h0028, 5, 220, 12); tick();
        check("clamp_ob0", int'(ob_b), 1);
        check("clamp_oba", int'(ob_a), 0);

        // 260 separate collisions saturate the counter.
        for (int c = 0; c < 260; c++) begin
            drive(16'h0028, 288, 220, 12); tick();
            check("sat_nonzero", (hc_a != 8'd0) ? 1 : 0, 1);
            drive(16'h0028, 287, 220, 12);
            repeat (REC + 1) tick();
        end
        check("sat_hc", int'(hc_a), 255);

        // Randomized traffic, positions clustered around the obstacle edges.
        for (int n = 0; n < 2000; n++) begin
            @(negedge frame_clk);
            Reset = ($urandom_range(0, 199) == 0);
            keycode = {pick_key(), pick_key()};
            if ($urandom_range(0, 9) < 4) begin
                if ($urandom_range(0, 9) == 0) BallX = 10'($urandom_range(0, 30));
                else BallX = 10'($urandom_range(250, 400));
                BallY = 10'($urandom_range(150, 290));
                BallS = 10'($urandom_range(0, 40));
            end
        end

        @(negedge frame_clk);
        Reset = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
